// File: rtl/io_pkg.sv
// Shared constants, FSM state type and BCD helper for the io_output_port block.
package io_pkg;

    localparam logic [1:0] PORT0_SEL = 2'b00;
    localparam logic [1:0] PORT1_SEL = 2'b01;
    localparam logic [1:0] PORT2_SEL = 2'b10;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Three decimal digits cover the largest legal DATA_W (9 bits, 511).
    localparam int unsigned BCD_W = 12;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_e;

    function automatic logic [BCD_W-1:0] bcd_adjust(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] r;
        r = bcd;
        for (int unsigned i = 0; i < BCD_W / 4; i++) begin
            if (r[i*4 +: 4] >= 4'd5) begin
                r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sevenseg_decoder.sv
// Hex digit to active-low gfedcba seven-segment pattern.
module sevenseg_decoder
    import io_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        unique case (digit_i)
            4'h0: seg_o = 7'b1000000;
            4'h1: seg_o = 7'b1111001;
            4'h2: seg_o = 7'b0100100;
            4'h3: seg_o = 7'b0110000;
            4'h4: seg_o = 7'b0011001;
            4'h5: seg_o = 7'b0010010;
            4'h6: seg_o = 7'b0000010;
            4'h7: seg_o = 7'b1111000;
            4'h8: seg_o = 7'b0000000;
            4'h9: seg_o = 7'b0010000;
            4'hA: seg_o = 7'b0001000;
            4'hB: seg_o = 7'b0000011;
            4'hC: seg_o = 7'b1000110;
            4'hD: seg_o = 7'b0100001;
            4'hE: seg_o = 7'b0000110;
            4'hF: seg_o = 7'b0001110;
        endcase
    end

endmodule

// File: rtl/io_output_port.sv
// Memory-mapped output ports with double-dabble BCD conversion of port 2 onto hex0..hex2.
// Optional macro IO_LEADING_ZERO_BLANK_EN blanks leading zero digits of the result.
module io_output_port
    import io_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned IO_BASE_BIT = 7
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [31:0] addr,
    input  logic [31:0] datain,
    input  logic        wmem,
    output logic [31:0] out_port0,
    output logic [31:0] out_port1,
    output logic [31:0] out_port2,
    output logic        busy,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5
);

    logic        wr_acc;
    logic [1:0]  wr_sel;
    logic        port2_wr;
    logic        unused_addr;

    logic [31:0] port0_q, port1_q, port2_q;

    conv_state_e             state_q, state_d;
    logic [DATA_W-1:0]       bin_q, bin_d;
    logic [BCD_W-1:0]        bcd_q, bcd_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [BCD_W-1:0]        disp_q, disp_d;

    logic [6:0] seg0, seg1, seg2;

    assign wr_acc      = wmem && addr[IO_BASE_BIT];
    assign wr_sel      = addr[3:2];
    assign port2_wr    = wr_acc && (wr_sel == PORT2_SEL);
    assign unused_addr = ^addr;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            port0_q <= '0;
            port1_q <= '0;
            port2_q <= '0;
        end else if (wr_acc) begin
            unique case (wr_sel)
                PORT0_SEL: port0_q <= datain;
                PORT1_SEL: port1_q <= datain;
                PORT2_SEL: port2_q <= datain;
                default:   ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            disp_q  <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            disp_q  <= disp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        disp_d  = disp_q;
        unique case (state_q)
            IDLE: ;
            SHIFT: begin
                {bcd_d, bin_d} = {bcd_adjust(bcd_q), bin_q} << 1;
                cnt_d          = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DATA_W - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                disp_d  = bcd_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A new port2 store restarts conversion from any state, including the
        // DONE cycle, so a stale result never reaches the display.
        if (port2_wr) begin
            state_d = SHIFT;
            bin_d   = datain[DATA_W-1:0];
            bcd_d   = '0;
            cnt_d   = '0;
            disp_d  = disp_q;
        end
    end

    assign busy      = (state_q != IDLE);
    assign out_port0 = port0_q;
    assign out_port1 = port1_q;
    assign out_port2 = port2_q;

    sevenseg_decoder u_dig0 (.digit_i(disp_q[3:0]),   .seg_o(seg0));
    sevenseg_decoder u_dig1 (.digit_i(disp_q[7:4]),   .seg_o(seg1));
    sevenseg_decoder u_dig2 (.digit_i(disp_q[11:8]),  .seg_o(seg2));
    sevenseg_decoder u_dig4 (.digit_i(port0_q[3:0]),  .seg_o(hex4));
    sevenseg_decoder u_dig5 (.digit_i(port1_q[3:0]),  .seg_o(hex5));

    assign hex0 = seg0;
    assign hex3 = SEG_BLANK;

`ifdef IO_LEADING_ZERO_BLANK_EN
    assign hex2 = (disp_q[11:8] == 4'd0) ? SEG_BLANK : seg2;
    assign hex1 = ((disp_q[11:8] == 4'd0) && (disp_q[7:4] == 4'd0)) ? SEG_BLANK : seg1;
`else
    assign hex2 = seg2;
    assign hex1 = seg1;
`endif

endmodule

// File: tb/tb_io_output_port.sv
// Scoreboard bench for io_output_port: random stores checked against a decimal reference model.
module tb_io_output_port;

    localparam int unsigned DATA_W = 8;
    localparam logic [6:0]  BLANK  = 7'b1111111;

    logic        clock  = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] addr   = '0;
    logic [31:0] datain = '0;
    logic        wmem   = 1'b0;
    logic [31:0] out_port0, out_port1, out_port2;
    logic        busy;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5;

    io_output_port #(.DATA_W(DATA_W), .IO_BASE_BIT(7)) dut (
        .clock(clock), .resetn(resetn), .addr(addr), .datain(datain), .wmem(wmem),
        .out_port0(out_port0), .out_port1(out_port1), .out_port2(out_port2),
        .busy(busy), .hex0(hex0), .hex1(hex1), .hex2(hex2),
        .hex3(hex3), .hex4(hex4), .hex5(hex5)
    );

    typedef struct {
        int unsigned value;
        int unsigned due;
    } conv_t;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned cyc   = 0;
    conv_t       pend[$];
    conv_t       done_c;
    logic [31:0] m_port [3];
    int unsigned m_disp = 0;
    logic        prev_busy = 1'b0;
    logic        exp_busy;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input int unsigned d);
        case (d)
            0: return 7'b1000000;   1: return 7'b1111001;
            2: return 7'b0100100;   3: return 7'b0110000;
            4: return 7'b0011001;   5: return 7'b0010010;
            6: return 7'b0000010;   7: return 7'b1111000;
            8: return 7'b0000000;   9: return 7'b0010000;
            10: return 7'b0001000;  11: return 7'b0000011;
            12: return 7'b1000110;  13: return 7'b0100001;
            14: return 7'b0000110;  default: return 7'b0001110;
        endcase
    endfunction

    function automatic logic [6:0] exp_digit(input int unsigned v, input int unsigned pos);
        int unsigned h;
        int unsigned t;
        int unsigned o;
        h = v / 100;
        t = (v / 10) % 10;
        o = v % 10;
`ifdef IO_LEADING_ZERO_BLANK_EN
        if (pos == 2 && h == 0) return BLANK;
        if (pos == 1 && h == 0 && t == 0) return BLANK;
`endif
        case (pos)
            0:       return seg_of(o);
            1:       return seg_of(t);
            default: return seg_of(h);
        endcase
    endfunction

    // Monitor: compares every visible output against the model once per cycle.
    always @(negedge clock) begin
        if (resetn && prev_busy && !busy) begin
            if (pend.size() == 0) begin
                total++;
                bad++;
                $display("FAIL done_unexpected t=%0t actual=busy_fell expected=no_conversion", $time);
            end else begin
                done_c = pend.pop_front();
                check("done_edge", cyc, done_c.due);
                m_disp = done_c.value;
            end
        end
        exp_busy = 1'b0;
        if (resetn && pend.size() > 0) begin
            if (cyc < pend[0].due) exp_busy = 1'b1;
        end
        check("busy", {31'd0, busy}, {31'd0, exp_busy});
        prev_busy = busy;
        check("out_port0", out_port0, m_port[0]);
        check("out_port1", out_port1, m_port[1]);
        check("out_port2", out_port2, m_port[2]);
        check("hex0", {25'd0, hex0}, {25'd0, exp_digit(m_disp, 0)});
        check("hex1", {25'd0, hex1}, {25'd0, exp_digit(m_disp, 1)});
        check("hex2", {25'd0, hex2}, {25'd0, exp_digit(m_disp, 2)});
        check("hex3", {25'd0, hex3}, {25'd0, BLANK});
        check("hex4", {25'd0, hex4}, {25'd0, seg_of(int'(m_port[0][3:0]))});
        check("hex5", {25'd0, hex5}, {25'd0, seg_of(int'(m_port[1][3:0]))});
    end

    task automatic model_clear();
        pend.delete();
        m_port[0] = '0;
        m_port[1] = '0;
        m_port[2] = '0;
        m_disp    = 0;
    endtask

    task automatic model_accept(input logic [1:0] sel, input logic [31:0] d, input int unsigned e);
        if (sel != 2'b11) m_port[sel] = d;
        if (sel == 2'b10) begin
            if (pend.size() > 0 && pend[$].due >= e) void'(pend.pop_back());
            pend.push_back('{value: int'(d) % (1 << DATA_W), due: e + DATA_W + 1});
        end
    endtask

    // Called at posedge+1; drives one cycle of stimulus, returns at posedge+1.
    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic we);
        int unsigned e;
        addr   = a;
        datain = d;
        wmem   = we;
        @(posedge clock);
        #1;
        e      = cyc;
        wmem   = 1'b0;
        addr   = $urandom;
        datain = $urandom;
        if (we && a[7]) model_accept(a[3:2], d, e);
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic pulse_reset(input int unsigned n);
        resetn = 1'b0;
        model_clear();
        #1;
        check("rst_busy_now", {31'd0, busy}, 32'd0);
        check("rst_hex0_now", {25'd0, hex0}, {25'd0, exp_digit(0, 0)});
        check("rst_hex2_now", {25'd0, hex2}, {25'd0, exp_digit(0, 2)});
        repeat (n) @(posedge clock);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        int unsigned guard;
        model_clear();
        repeat (3) @(posedge clock);
        #1;
        resetn = 1'b1;
        idle(1);

        do_write(32'h80, 32'd6, 1'b1);
        check("port0_hex4", {25'd0, hex4}, {25'd0, 7'b0000010});
        do_write(32'h84, 32'd11, 1'b1);
        check("port1_hex5", {25'd0, hex5}, {25'd0, 7'b0000011});

        do_write(32'h88, 32'd17, 1'b1);
        idle(DATA_W + 3);
        check("val17_hex1", {25'd0, hex1}, {25'd0, 7'b1111001});
        check("val17_hex0", {25'd0, hex0}, {25'd0, 7'b1111000});

        do_write(32'h88, 32'd255, 1'b1);
        idle(2);
        do_write(32'h88, 32'd42, 1'b1);
        idle(DATA_W + 3);

        do_write(32'h8C, 32'hDEAD_BEEF, 1'b1);
        do_write(32'h08, 32'h1234_5678, 1'b1);
        do_write(32'h88, 32'd99, 1'b0);
        idle(2);

        do_write(32'h88, 32'd42, 1'b1);
        idle(DATA_W + 3);
        do_write(32'h88, 32'd42, 1'b1);
        idle(DATA_W + 3);
        do_write(32'h88, 32'h100, 1'b1);
        idle(DATA_W + 3);
        do_write(32'h88, 32'd5, 1'b1);
        idle(DATA_W + 3);

        do_write(32'h88, 32'd200, 1'b1);
        idle(4);
        do_write(32'h80, 32'd9, 1'b1);
        do_write(32'h84, 32'd3, 1'b1);
        idle(DATA_W);

        do_write(32'h88, 32'd123, 1'b1);
        idle(4);
        pulse_reset(2);
        idle(3);

        for (int i = 0; i < 300; i++) begin
            a      = $urandom;
            a[7]   = ($urandom_range(0, 7) != 0);
            a[3:2] = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) a[3:2] = 2'b10;
            d = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 600)) : $urandom;
            do_write(a, d, $urandom_range(0, 5) != 0);
            idle($urandom_range(0, 12));
            if ($urandom_range(0, 49) == 0) pulse_reset($urandom_range(1, 3));
        end

        guard = 0;
        while (pend.size() > 0 && guard < 40) begin
            idle(1);
            guard++;
        end
        total++;
        if (pend.size() != 0) begin
            bad++;
            $display("FAIL drain_timeout actual=%0d_pending expected=0_pending", pend.size());
        end
        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/io_output_port.md
Name: io_output_port

Overview:
Memory-mapped output port block for pipelined_computer: the write-side counterpart of the switch input ports (in_port0/in_port1).
- CPU store instructions to the I/O window latch three 32-bit output registers.
- out_port2, the computed result, is converted to decimal by a multi-cycle double-dabble FSM.
- All displayed values drive active-low seven-segment outputs hex0..hex5 on the DE-class board.

Parameters:
DATA_W, 8, number of low out_port2 bits converted to BCD; legal range 4..9 (three decimal digits max).
IO_BASE_BIT, 7, address bit that selects the I/O window (addr[IO_BASE_BIT]=1).

Ports:
clock  in  1  system clock, same clock as the CPU core.
resetn  in  1  asynchronous reset, active-low.
addr  in  32  CPU data address (MEM-stage malu).
datain  in  32  CPU store data.
wmem  in  1  CPU store enable; a write is accepted when wmem=1 and addr[IO_BASE_BIT]=1.
out_port0  out  32  latched port 0.
out_port1  out  32  latched port 1.
out_port2  out  32  latched port 2 (result).
busy  out  1  BCD conversion in progress.
hex0,hex1,hex2  out  7 each  result ones/tens/hundreds, gfedcba, active-low.
hex3  out  7  always blank (7'b1111111).
hex4  out  7  out_port0[3:0] as a hex digit.
hex5  out  7  out_port1[3:0] as a hex digit.

Behaviour:
Reset (async, resetn=0):
- out_port0/1/2 = 0, busy = 0, FSM = IDLE, BCD display register = 0.
- hex0..hex2 and hex4..hex5 show "0" (7'b1000000); hex3 is blank.

Address decode (valid only when addr[IO_BASE_BIT]=1):
- addr[3:2]=00 selects port0; 01 selects port1; 10 selects port2.
- addr[3:2]=11 is ignored: no register changes.
- A selected port register updates on the rising edge where the write is accepted.

Conversion FSM:
- States: IDLE, SHIFT, DONE.
- IDLE -> SHIFT on an accepted port2 write. Load shift register = datain[DATA_W-1:0] and BCD accumulator = 0; the shift counter counts DATA_W steps.
- SHIFT, per cycle: every BCD nibble >=5 gets +3, then a 1-bit left shift of {bcd, bin}. After DATA_W shifts, go to DONE.
- DONE: copy accumulator into the display register; next state IDLE.
- busy=1 in SHIFT and DONE.

Latency:
- Write accepted at edge N: busy rises after edge N.
- Display register and hex0..hex2 update at edge N+DATA_W+1; busy falls at the same edge.
- hex4/hex5 follow out_port0/1 combinationally from the registers, so they are valid after edge N.

Boundary conditions:
- Port2 write while busy: the in-flight conversion is aborted and restarts from the new value, with the full latency counted from the new edge. The display holds its old value until the restarted conversion completes.
- Port0/1 writes while busy do not disturb the FSM.
- Repeated writes of an identical value still run a full conversion.
- Bits of out_port2 above DATA_W-1 are stored but ignored for display. Example: 0x100 with DATA_W=8 displays 000.
- resetn asserted mid-conversion: FSM returns to IDLE immediately, the display clears to 0 and the conversion result is discarded.

Optional Feature:
IO_LEADING_ZERO_BLANK_EN
- Defined: hex2 is blank when the hundreds digit is 0. hex1 is blank when both the hundreds and tens digits are 0. hex0 is never blanked. Reset display: hex0="0", hex1/hex2 blank.
- Undefined: all three result digits always display, including leading zeros.

Decomposition:
- Package io_pkg holds:
  - port address index constants (PORT0_SEL=2'b00, PORT1_SEL=2'b01, PORT2_SEL=2'b10);
  - the FSM state enum;
  - the SEG_BLANK constant (7'b1111111).
- Sub-module sevenseg_decoder: 4-bit in, 7-bit active-low out, codes 0-F. Instantiated five times.

Test Plan:
1. Reset held then released -> hex0,hex1,hex2,hex4,hex5 = 7'b1000000 and hex3 = 7'b1111111 (feature off); busy=0.
2. Write port0=6 (addr 0x80), then port1=11 (addr 0x84) -> hex4=7'b0000010 ("6") and hex5=7'b0000011 ("b") after each write edge.
3. Write port2=17 (addr 0x88) at edge N -> busy high for 9 cycles; at edge N+9, hex1=7'b1111001 ("1"), hex0=7'b1111000 ("7"), hex2="0".
4. Write port2=255, then write port2=42 three cycles later -> display never shows 255; 42 appears at (second write edge)+9.
5. Write to addr 0x8C, and write with addr[7]=0 -> out_port0..2 unchanged, busy stays 0.
6. Feature on: write port2=5 -> hex0="5" (7'b0010010); hex1 and hex2 are 7'b1111111. Pulse resetn low mid-conversion -> busy=0 immediately and the display shows 0.
